// File: rtl/adder_128b_seq_if.sv
// adder_128b_seq_if: operand and result valid/ready channels.
// master drives operands and result ready; slave is the sequencer.
interface adder_128b_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in0;
    logic [127:0] in1;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out0;
    logic         out1;

    modport master (
        output in_valid, in0, in1, out_ready,
        input  in_ready, out_valid, out0, out1
    );

    modport slave (
        input  in_valid, in0, in1, out_ready,
        output in_ready, out_valid, out0, out1
    );
endinterface

// File: rtl/adder_128b_seq.sv
// adder_128b_seq: 128-bit add time-shared over one SLICE_W-bit slice
// with a registered carry between slices.
module adder_128b_seq #(
    parameter int SLICE_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_128b_seq_if.slave        bus,
    output logic [31:0]            ops_done
);
    localparam int N  = 128 / SLICE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((SLICE_W < 1) || (SLICE_W > 128) ||
            ((SLICE_W & (SLICE_W - 1)) != 0)) begin : g_bad_slice
            $error("SLICE_W must be a power of two from 1 to 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   a_reg;
    logic [127:0]   b_reg;
    logic [127:0]   sum_reg;
    logic           carry;
    logic [IW-1:0]  idx;
    logic [7:0]     base;
    logic [SLICE_W:0] slice_sum;
    logic           last;

    // base never exceeds 128-SLICE_W, so 8 bits always suffice
    always_comb begin
        base      = 8'(idx) * 8'(SLICE_W);
        slice_sum = {1'b0, a_reg[base +: SLICE_W]}
                  + {1'b0, b_reg[base +: SLICE_W]}
                  + {{SLICE_W{1'b0}}, carry};
        last      = (idx == IW'(N - 1));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg   <= bus.in0;
                        b_reg   <= bus.in1;
                        sum_reg <= '0;
                        carry   <= 1'b0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_reg[base +: SLICE_W] <= slice_sum[SLICE_W-1:0];
                    carry <= slice_sum[SLICE_W];
                    idx   <= idx + IW'(1);
                end
                DONE: begin
                    if (bus.out_ready) ops_done <= ops_done + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out0      = sum_reg;
    assign bus.out1      = carry;
endmodule
